// File: rtl/sort8_result_stage_if.sv
// Handshake bundle between the bitonic sorter, this result stage and its consumer.
// The slave modport is the result stage's view; master is the surrounding environment.
interface sort8_result_stage_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_therm;
  logic [3:0] m_count;
  logic       m_err;

  modport slave (
    input  s_valid,
    input  s_data,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_therm,
    output m_count,
    output m_err
  );

  modport master (
    output s_valid,
    output s_data,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_therm,
    input  m_count,
    input  m_err
  );
endinterface

// File: rtl/sort8_result_stage.sv
// Registers the sorted 8-bit word, checks thermometer form, encodes a one-count and hands
// results downstream through a 2-entry skid buffer; counts malformed words with saturation.
module sort8_result_stage #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sort8_result_stage_if.slave  bus,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  localparam logic [ERR_CNT_W-1:0] ErrMax = '1;
  localparam logic [ERR_CNT_W-1:0] ErrOne = ERR_CNT_W'(1);

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, d[i]};
    return c;
  endfunction

  state_e               state_q, state_d;
  logic [7:0]           therm_q, therm_d, skid_therm_q, skid_therm_d;
  logic [3:0]           count_q, count_d, skid_count_q, skid_count_d;
  logic                 err_q, err_d, skid_err_q, skid_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       accept, xfer, in_err;
  logic [3:0] in_count;

  // Legal iff no set bit has a clear bit directly above it (bit 7 has nothing above).
  assign in_err   = |((bus.s_data & ~(bus.s_data >> 1)) & 8'h7F);
  assign in_count = popcount8(bus.s_data);

  // Both handshake outputs decode the state register only, so neither sees m_ready.
  assign bus.s_ready = (state_q != StFull);
  assign bus.m_valid = (state_q != StEmpty);
  assign bus.m_therm = therm_q;
  assign bus.m_count = count_q;
  assign bus.m_err   = err_q;
  assign err_cnt     = err_cnt_q;

  assign accept = bus.s_valid && bus.s_ready;
  assign xfer   = bus.m_valid && bus.m_ready;

  always_comb begin
    state_d      = state_q;
    therm_d      = therm_q;
    count_d      = count_q;
    err_d        = err_q;
    skid_therm_d = skid_therm_q;
    skid_count_d = skid_count_q;
    skid_err_d   = skid_err_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          therm_d = bus.s_data;
          count_d = in_count;
          err_d   = in_err;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && xfer) begin
          therm_d = bus.s_data;
          count_d = in_count;
          err_d   = in_err;
        end else if (accept) begin
          skid_therm_d = bus.s_data;
          skid_count_d = in_count;
          skid_err_d   = in_err;
          state_d      = StFull;
        end else if (xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (xfer) begin
          therm_d = skid_therm_q;
          count_d = skid_count_q;
          err_d   = skid_err_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // An illegal accept outranks a simultaneous clear, restarting the count at one.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && in_err) begin
      if (err_clr)                 err_cnt_d = ErrOne;
      else if (err_cnt_q != ErrMax) err_cnt_d = err_cnt_q + ErrOne;
    end else if (err_clr) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StEmpty;
      therm_q      <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      skid_therm_q <= '0;
      skid_count_q <= '0;
      skid_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      therm_q      <= therm_d;
      count_q      <= count_d;
      err_q        <= err_d;
      skid_therm_q <= skid_therm_d;
      skid_count_q <= skid_count_d;
      skid_err_q   <= skid_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_sort8_result_stage.sv
// Directed bench for sort8_result_stage: a default-width and a 2-bit-counter instance share
// one stimulus stream; a queue scoreboard predicts every output word and the error counts.
module tb_sort8_result_stage;

  typedef struct packed {
    logic [7:0] therm;
    logic [3:0] count;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       err_clr = 1'b0;
  logic [7:0] err_cnt8;
  logic [1:0] err_cnt2;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   err8 = 0;
  int   err2 = 0;

  sort8_result_stage_if bus_a ();
  sort8_result_stage_if bus_b ();

  assign bus_b.s_valid = bus_a.s_valid;
  assign bus_b.s_data  = bus_a.s_data;
  assign bus_b.m_ready = bus_a.m_ready;

  sort8_result_stage #(.ERR_CNT_W(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_a),
    .err_clr (err_clr),
    .err_cnt (err_cnt8)
  );

  sort8_result_stage #(.ERR_CNT_W(2)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_b),
    .err_clr (err_clr),
    .err_cnt (err_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [7:0] d);
    logic [7:0] t;
    for (int k = 0; k <= 8; k++) begin
      t = ~(8'hFF >> k);
      if (d == t) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] ones(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) if (d[i]) n++;
    return 4'(n);
  endfunction

  // Compare current outputs against the model, then advance one clock and update the model.
  task automatic step();
    bit   exp_ready, acc, xf, ill;
    exp_t e;
    exp_ready = (q.size() < 2);
    check("s_ready", 32'(bus_a.s_ready), 32'(exp_ready));
    check("m_valid", 32'(bus_a.m_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("m_therm", 32'(bus_a.m_therm), 32'(q[0].therm));
      check("m_count", 32'(bus_a.m_count), 32'(q[0].count));
      check("m_err", 32'(bus_a.m_err), 32'(q[0].err));
    end
    check("err_cnt8", 32'(err_cnt8), 32'(err8));
    check("err_cnt2", 32'(err_cnt2), 32'(err2));
    acc = bus_a.s_valid && exp_ready;
    xf  = (q.size() > 0) && bus_a.m_ready;
    ill = !is_legal(bus_a.s_data);
    e.therm = bus_a.s_data;
    e.count = ones(bus_a.s_data);
    e.err   = ill;
    if (acc && ill) begin
      err8 = err_clr ? 1 : ((err8 == 255) ? 255 : err8 + 1);
      err2 = err_clr ? 1 : ((err2 == 3) ? 3 : err2 + 1);
    end else if (err_clr) begin
      err8 = 0;
      err2 = 0;
    end
    @(posedge clk);
    #1;
    if (xf) void'(q.pop_front());
    if (acc) q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    bus_a.s_valid = v;
    bus_a.s_data  = d;
    bus_a.m_ready = r;
    step();
  endtask

  initial begin
    bus_a.s_valid = 1'b0;
    bus_a.s_data  = 8'h00;
    bus_a.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_therm", 32'(bus_a.m_therm), 32'h0);
    check("rst_m_count", 32'(bus_a.m_count), 32'h0);
    check("rst_m_err", 32'(bus_a.m_err), 32'h0);
    rst = 1'b0;
    step();

    // Single legal word
    drive(1'b1, 8'hF0, 1'b1);
    check("f0_count", 32'(bus_a.m_count), 32'd4);
    drive(1'b0, 8'h00, 1'b1);

    // Back-to-back stream
    drive(1'b1, 8'h00, 1'b1);
    drive(1'b1, 8'h80, 1'b1);
    drive(1'b1, 8'hFF, 1'b1);
    check("ff_count", 32'(bus_a.m_count), 32'd8);
    drive(1'b0, 8'h00, 1'b1);

    // Back-pressure: C stalls until the skid drains
    drive(1'b1, 8'hC0, 1'b0);
    drive(1'b1, 8'hE0, 1'b0);
    check("full_s_ready", 32'(bus_a.s_ready), 32'h0);
    drive(1'b1, 8'hF8, 1'b0);
    drive(1'b1, 8'hF8, 1'b0);
    drive(1'b1, 8'hF8, 1'b1);
    drive(1'b1, 8'hF8, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);

    // Illegal words
    drive(1'b1, 8'h0F, 1'b1);
    drive(1'b1, 8'h5A, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    check("err_cnt_two", 32'(err_cnt8), 32'd2);

    // Saturation of the narrow counter
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h01 << i, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    check("err2_sat", 32'(err_cnt2), 32'd3);

    err_clr = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    err_clr = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    err_clr = 1'b1;
    drive(1'b1, 8'h0F, 1'b1);
    err_clr = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    check("clr_inc_wins", 32'(err_cnt8), 32'd1);

    // Fill to FULL, then reset asynchronously mid-cycle
    drive(1'b1, 8'hFE, 1'b0);
    drive(1'b1, 8'h3C, 1'b0);
    bus_a.s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_m_valid", 32'(bus_a.m_valid), 32'h0);
    check("arst_s_ready", 32'(bus_a.s_ready), 32'h1);
    check("arst_err_cnt", 32'(err_cnt8), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    err8 = 0;
    err2 = 0;
    drive(1'b1, 8'hFC, 1'b1);
    check("post_rst_first", 32'(bus_a.m_therm), 32'hFC);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort8_result_stage.md
Name: sort8_result_stage

Overview:
- Sits directly downstream of the 8-input single-bit bitonic sorter and registers its combinational output.
- Sorted output is ascending with out[0] as the minimum, so a valid word is a thermometer code: ones packed toward bit 7, zeros toward bit 0.
- The block checks the thermometer form and encodes it into a one-count (0..8).
- It delivers results over a valid/ready interface through a 2-entry skid buffer, and keeps a saturating count of malformed words.

Parameters:
- ERR_CNT_W, 8, width of the saturating malformed-word counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- s_valid  input  1  sorter word on s_data is valid.
- s_ready  output  1  block can accept a word this cycle.
- s_data  input  8  sorted word from the sorter (bit 0 = min, bit 7 = max).
- m_valid  output  1  result available.
- m_ready  input  1  consumer accepts the result this cycle.
- m_therm  output  8  registered copy of the accepted sorted word.
- m_count  output  4  number of ones in m_therm (0..8).
- m_err  output  1  m_therm is not a legal thermometer code.
- err_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  ERR_CNT_W  saturating count of malformed words accepted.

Behaviour:
- Reset (asynchronous, active-high, immediate): state EMPTY; m_valid=0, m_therm=0, m_count=0, m_err=0, err_cnt=0, s_ready=1. Reset mid-transfer discards any buffered words.
- Legal thermometer: s_data == ~((8'hFF) >> k) for some k in 0..8, i.e. ones in bits [7:8-k] and zeros below. Equivalently, for every i<7, s_data[i]=1 implies s_data[i+1]=1.
- Count is popcount(s_data), computed at acceptance and registered with the word. The count is reported even when the word is illegal.
- Accept on the input side: s_valid && s_ready. Transfer on the output side: m_valid && m_ready.
- Latency: an accepted word appears on m_* in the next cycle when the output register is free.
- s_ready is registered and equals (state != FULL). It never depends combinationally on m_ready.
- States:
  - EMPTY: out register invalid.
    - Accept: load out register, go to ONE.
  - ONE: out register valid, skid empty.
    - Accept with no transfer: load skid, go to FULL.
    - Accept with transfer: load out register, stay in ONE.
    - Transfer with no accept: go to EMPTY.
    - Neither: hold.
  - FULL: out register and skid both valid; s_ready=0.
    - Transfer: move skid into out register, go to ONE.
    - No transfer: hold.
- Word order is strictly FIFO. No word is dropped or duplicated.
- m_therm, m_count and m_err stay stable while m_valid=1 and m_ready=0.
- err_cnt increments by 1 on each accepted illegal word and saturates at 2^ERR_CNT_W-1.
- If err_clr is asserted in the same cycle as an illegal accept, err_cnt becomes 1 (the increment wins over the clear).
- err_clr alone forces err_cnt to 0.
- Output signals are don't-care in value when m_valid=0. They keep their last value and are not cleared.

Test Plan:
- Reset, then s_data=8'hF0 with s_valid=1 and m_ready=1 -> next cycle m_valid=1, m_therm=F0, m_count=4, m_err=0; err_cnt=0.
- Stream 8'h00, 8'h80, 8'hFF back-to-back with m_ready=1 -> counts 0, 1, 8 on consecutive cycles; s_ready stays 1 throughout.
- Hold m_ready=0 and offer 3 words A=C0, B=E0, C=F8 -> A and B accepted, s_ready=0 after B, C stalled. Raise m_ready -> outputs A, B, C in order with counts 2, 3, 5.
- Illegal s_data=8'h0F, then 8'h5A -> m_err=1 for both with counts 4 and 4; err_cnt=2.
- Set ERR_CNT_W=2 and send 5 illegal words -> err_cnt saturates at 3. Pulse err_clr -> 0. err_clr together with an illegal accept -> 1.
- Assert rst while in FULL -> m_valid=0, s_ready=1, err_cnt=0 immediately; the next accepted word emerges first.
